// File: rtl/control_unit.sv
// control_unit: fetch/exec/halt sequencer that fetches 8-bit instructions and decodes accumulator/register control.
module control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       CLK,
  input  logic       CLB,
  input  logic       Run,
  output logic       PM_Req,
  output logic [7:0] PM_Addr,
  input  logic       PM_Ack,
  input  logic [7:0] PM_Data,
  input  logic       Zero,
  output logic [3:0] A_Imm,
  output logic       LoadAcc,
  output logic       SelAcc1,
  output logic       SelAcc0,
  output logic [3:0] RegAddr,
  output logic       RegWrite,
  output logic [2:0] AluOp,
  output logic       Halted,
  output logic       IllegalOp
);
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       req_q, req_d;
  logic [3:0] opc, opr;
  logic       ex;

  assign opc = ir_q[7:4];
  assign opr = ir_q[3:0];
  assign ex  = state_q == EXEC;

  // request is registered and raised straight out of EXEC so a 1-cycle memory gives 3 cycles per instruction
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = 1'b0;
    if (state_q == FETCH) begin
      if (req_q && PM_Ack) begin
        ir_d    = PM_Data;
        pc_d    = pc_q + 8'd1;
        state_d = EXEC;
      end else req_d = req_q | Run;
    end else if (ex) begin
      state_d = opc == 4'hF ? HALT : FETCH;
      req_d   = opc != 4'hF && Run;
      if (opc == 4'h5 || (opc == 4'h6 && Zero)) pc_d = {opr, 4'h0};
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLB) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
    end
  end

  assign PM_Req    = req_q;
  assign PM_Addr   = pc_q;
  assign Halted    = state_q == HALT;
  assign A_Imm     = ex && opc == 4'h1 ? opr : 4'h0;
  assign LoadAcc   = ex && (opc == 4'h1 || opc == 4'h2 || opc == 4'h3);
  assign SelAcc1   = ex && opc == 4'h3;
  assign SelAcc0   = ex && opc == 4'h2;
  assign RegAddr   = ex && (opc == 4'h2 || opc == 4'h4) ? opr : 4'h0;
  assign RegWrite  = ex && opc == 4'h4;
  assign AluOp     = ex && opc == 4'h3 ? opr[2:0] : 3'd0;
  assign IllegalOp = ex && opc >= 4'h7 && opc <= 4'hE;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed scenario tests for control_unit against a latency-programmable program memory.
module tb_control_unit;
  localparam logic [7:0] RST = 8'h10;

  logic       CLK = 1'b0, CLB = 1'b0, Run = 1'b0, PM_Ack = 1'b0, Zero = 1'b0;
  logic [7:0] PM_Data = 8'h00;
  logic       PM_Req, LoadAcc, SelAcc1, SelAcc0, RegWrite, Halted, IllegalOp;
  logic [7:0] PM_Addr;
  logic [3:0] A_Imm, RegAddr;
  logic [2:0] AluOp;
  logic [7:0] mem [256];
  int         lat = 1, wait_cnt = 0, errors = 0, checks = 0;
  logic [25:0] outs;
  logic [25:0] rst_outs;

  control_unit #(.RESET_PC(RST)) dut (
    .CLK(CLK), .CLB(CLB), .Run(Run), .PM_Req(PM_Req), .PM_Addr(PM_Addr),
    .PM_Ack(PM_Ack), .PM_Data(PM_Data), .Zero(Zero), .A_Imm(A_Imm),
    .LoadAcc(LoadAcc), .SelAcc1(SelAcc1), .SelAcc0(SelAcc0), .RegAddr(RegAddr),
    .RegWrite(RegWrite), .AluOp(AluOp), .Halted(Halted), .IllegalOp(IllegalOp)
  );

  assign outs = {PM_Req, PM_Addr, A_Imm, LoadAcc, SelAcc1, SelAcc0, RegAddr, RegWrite, AluOp, Halted, IllegalOp};
  assign rst_outs = {1'b0, RST, 17'h0};

  always #5 CLK = ~CLK;

  // memory acks lat cycles after it first sees the request
  always @(posedge CLK) begin
    #1;
    if (PM_Req) begin
      if (wait_cnt >= lat) begin
        PM_Ack = 1'b1;
        PM_Data = mem[PM_Addr];
        wait_cnt = 0;
      end else begin
        PM_Ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      PM_Ack = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    CLB = 1'b0;
    Run = 1'b0;
    cyc();
    CLB = 1'b1;
  endtask

  task automatic next_exec(output int n);
    logic prev;
    n = 0;
    do begin
      prev = PM_Ack;
      cyc();
      n++;
    end while (!prev && n < 40);
    if (!prev) begin
      checks++; errors++;
      $display("FAIL exec_timeout: no PM_Ack within %0d cycles", n);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!PM_Req && n < 20) begin cyc(); n++; end
    checks++;
    if (!PM_Req) begin errors++; $display("FAIL req_timeout: PM_Req=%b need 1", PM_Req); end
  endtask

  task automatic test_reset();
    CLB = 1'b0;
    Run = 1'b1;
    cyc();
    cyc();
    checks++;
    if (outs !== rst_outs) begin errors++; $display("FAIL reset_outs: got %h need %h", outs, rst_outs); end
  endtask

  task automatic test_program();
    int n;
    do_reset();
    mem[RST] = 8'h13; mem[RST+1] = 8'h40; mem[RST+2] = 8'h21; mem[RST+3] = 8'hF0;
    Run = 1'b1;
    next_exec(n);
    checks++;
    if ({LoadAcc, SelAcc1, SelAcc0, A_Imm, RegWrite, IllegalOp} !== {3'b100, 4'h3, 2'b00})
      begin errors++; $display("FAIL ldi: got L%b S%b%b I%h W%b X%b", LoadAcc, SelAcc1, SelAcc0, A_Imm, RegWrite, IllegalOp); end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL first_latency: got %0d need 3", n); end
    next_exec(n);
    checks++;
    if ({RegWrite, RegAddr, LoadAcc} !== {1'b1, 4'h0, 1'b0}) begin errors++; $display("FAIL str: got W%b R%h L%b", RegWrite, RegAddr, LoadAcc); end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL throughput: got %0d need 3", n); end
    next_exec(n);
    checks++;
    if ({LoadAcc, SelAcc1, SelAcc0, RegAddr, RegWrite} !== {3'b101, 4'h1, 1'b0})
      begin errors++; $display("FAIL ldr: got L%b S%b%b R%h W%b", LoadAcc, SelAcc1, SelAcc0, RegAddr, RegWrite); end
    next_exec(n);
    checks++;
    if ({LoadAcc, RegWrite, IllegalOp, Halted, PM_Req} !== 5'b0) begin errors++; $display("FAIL hlt_exec: got %b need 00000", {LoadAcc, RegWrite, IllegalOp, Halted, PM_Req}); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if ({Halted, PM_Req, LoadAcc, RegWrite} !== 4'b1000) begin errors++; $display("FAIL halted_%0d: got %b need 1000", i, {Halted, PM_Req, LoadAcc, RegWrite}); end
    end
  endtask

  task automatic test_decode();
    int n;
    do_reset();
    mem[RST] = 8'h3D; mem[RST+1] = 8'h47; mem[RST+2] = 8'h00;
    Run = 1'b1;
    next_exec(n);
    checks++;
    if ({LoadAcc, SelAcc1, AluOp, RegWrite, A_Imm} !== {2'b11, 3'd5, 1'b0, 4'h0}) begin errors++; $display("FAIL alu: got L%b S1%b op%0d W%b I%h", LoadAcc, SelAcc1, AluOp, RegWrite, A_Imm); end
    next_exec(n);
    checks++;
    if ({RegWrite, RegAddr, LoadAcc, AluOp} !== {1'b1, 4'h7, 1'b0, 3'd0}) begin errors++; $display("FAIL str7: got W%b R%h L%b op%0d", RegWrite, RegAddr, LoadAcc, AluOp); end
    next_exec(n);
    checks++;
    if (outs[16:0] !== 17'h0) begin errors++; $display("FAIL nop: got %h need 0", outs[16:0]); end
    Run = 1'b0;
  endtask

  task automatic test_jz();
    int n;
    do_reset();
    mem[RST] = 8'h6A; mem[8'hA0] = 8'h6A; mem[8'hA1] = 8'h5C;
    Zero = 1'b1;
    Run = 1'b1;
    next_exec(n);
    cyc();
    checks++;
    if (PM_Addr !== 8'hA0) begin errors++; $display("FAIL jz_taken: got %h need a0", PM_Addr); end
    Zero = 1'b0;
    next_exec(n);
    cyc();
    checks++;
    if (PM_Addr !== 8'hA1) begin errors++; $display("FAIL jz_not_taken: got %h need a1", PM_Addr); end
    Zero = 1'b1;
    next_exec(n);
    Run = 1'b0;
    cyc();
    checks++;
    if (PM_Addr !== 8'hC0) begin errors++; $display("FAIL jmp: got %h need c0", PM_Addr); end
    Zero = 1'b0;
  endtask

  task automatic test_wait_run();
    int n, pulses;
    do_reset();
    mem[RST] = 8'h13;
    lat = 5;
    Run = 1'b1;
    wait_req();
    n = 0;
    while (!PM_Ack && n < 12) begin
      checks++;
      if ({PM_Req, PM_Addr} !== {1'b1, RST}) begin errors++; $display("FAIL wait_stable_%0d: got %b %h need 1 %h", n, PM_Req, PM_Addr, RST); end
      if (n == 1) Run = 1'b0;
      cyc();
      n++;
    end
    checks++;
    if (!PM_Ack || n !== 5) begin errors++; $display("FAIL wait_len: got ack=%b after %0d need 1 after 5", PM_Ack, n); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (LoadAcc) pulses++;
    end
    checks++;
    if ({pulses, PM_Req, PM_Addr} !== {32'd1, 1'b0, RST + 8'd1}) begin errors++; $display("FAIL exec_once: got %0d pulses req=%b addr=%h need 1 0 %h", pulses, PM_Req, PM_Addr, RST + 8'd1); end
    lat = 1;
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    mem[RST] = 8'h5F;
    for (int i = 8'hF0; i <= 8'hFF; i++) mem[i] = 8'h00;
    Run = 1'b1;
    next_exec(n);
    for (int i = 0; i < 16; i++) next_exec(n);
    Run = 1'b0;
    cyc();
    checks++;
    if (PM_Addr !== 8'h00) begin errors++; $display("FAIL pc_wrap: got %h need 00", PM_Addr); end
  endtask

  task automatic test_illegal();
    int n;
    do_reset();
    mem[RST] = 8'h95;
    Run = 1'b1;
    next_exec(n);
    Run = 1'b0;
    checks++;
    if ({IllegalOp, LoadAcc, RegWrite} !== 3'b100) begin errors++; $display("FAIL illegal_pulse: got %b need 100", {IllegalOp, LoadAcc, RegWrite}); end
    cyc();
    checks++;
    if ({IllegalOp, PM_Addr, Halted} !== {1'b0, RST + 8'd1, 1'b0}) begin errors++; $display("FAIL illegal_after: got %b %h %b need 0 %h 0", IllegalOp, PM_Addr, Halted, RST + 8'd1); end
  endtask

  task automatic test_reset_ack();
    int n = 0, k;
    do_reset();
    mem[RST] = 8'h13;
    Run = 1'b1;
    while (!PM_Ack && n < 20) begin cyc(); n++; end
    CLB = 1'b0;
    cyc();
    checks++;
    if (outs !== rst_outs) begin errors++; $display("FAIL reset_in_ack: got %h need %h", outs, rst_outs); end
    CLB = 1'b1;
    wait_req();
    checks++;
    if (PM_Addr !== RST) begin errors++; $display("FAIL refetch_addr: got %h need %h", PM_Addr, RST); end
    next_exec(k);
    checks++;
    if ({LoadAcc, A_Imm} !== {1'b1, 4'h3}) begin errors++; $display("FAIL refetch_exec: got L%b I%h need L1 I3", LoadAcc, A_Imm); end
  endtask

  task automatic test_reset_halt();
    int n;
    do_reset();
    mem[RST] = 8'hF0;
    Run = 1'b1;
    next_exec(n);
    cyc();
    checks++;
    if (Halted !== 1'b1) begin errors++; $display("FAIL halt_enter: got %b need 1", Halted); end
    CLB = 1'b0;
    cyc();
    checks++;
    if (outs !== rst_outs) begin errors++; $display("FAIL reset_in_halt: got %h need %h", outs, rst_outs); end
    CLB = 1'b1;
    mem[RST] = 8'h00;
    wait_req();
    checks++;
    if ({PM_Addr, Halted} !== {RST, 1'b0}) begin errors++; $display("FAIL halt_refetch: got %h %b need %h 0", PM_Addr, Halted, RST); end
    Run = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_program();
    test_decode();
    test_jz();
    test_wait_run();
    test_wrap();
    test_illegal();
    test_reset_ack();
    test_reset_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
